// File: rtl/scanline_pkg.sv
// Shared types and helpers for the scanline UART framer.
// Macro SCANLINE_FRAMER_CHECKSUM_EN appends an XOR checksum byte to every frame.
package scanline_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  localparam logic [7:0] SyncByteDefault = 8'hA5;

  // Bytes per frame: sync, address, data and the optional checksum.
  function automatic int unsigned frame_len(input int unsigned line_bits,
                                            input int unsigned addr_bytes);
    int unsigned n;
    n = 1 + addr_bytes + line_bits / 8;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
    n = n + 1;
`endif
    return n;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 (or 8N2) byte serialiser. byte_ready rises in the final stop-bit cycle so a
// waiting byte follows with no idle gap.
module uart_byte_tx import scanline_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    byte_ready = 1'b0;
    bit_end    = (cnt_q == CntLast);
    if (!bit_end) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
    end
    unique case (state_q)
      StIdle: begin
        byte_ready = 1'b1;
        cnt_d      = '0;
        if (byte_valid) begin
          state_d = StStart;
          tx_d    = 1'b0;
          sh_d    = byte_data;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            byte_ready = 1'b1;
            if (byte_valid) begin
              state_d = StStart;
              tx_d    = 1'b0;
              sh_d    = byte_data;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/scanline_uart_framer.sv
// Frames one scanline (sync, address LS byte first, data LS byte first) onto a UART line.
// Macro SCANLINE_FRAMER_CHECKSUM_EN appends the XOR of all address and data bytes.
module scanline_uart_framer import scanline_pkg::*; #(
  parameter int unsigned LINE_BITS    = 160,
  parameter int unsigned ADDR_BYTES   = 1,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sl_valid,
  input  logic [LINE_BITS-1:0]    sl_data,
  input  logic [8*ADDR_BYTES-1:0] sl_addr,
  output logic                    sl_ready,
  output logic                    uart_tx,
  output logic                    busy
);

  localparam int unsigned NumBytes = frame_len(LINE_BITS, ADDR_BYTES);
  localparam int unsigned IdxW = $clog2(NumBytes) + 1;
  localparam int unsigned PayW = 8 * ADDR_BYTES + LINE_BITS;
  localparam logic [IdxW-1:0] IdxEnd = IdxW'(NumBytes);

  logic            busy_q, busy_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [PayW-1:0] pay_q, pay_d;
  logic            accept, byte_valid, byte_ready, byte_fire, frame_done;
  logic [7:0]      byte_data;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
  localparam logic [IdxW-1:0] IdxCsum = IdxW'(NumBytes - 1);
  logic [7:0] csum_q, csum_d;
`endif

  always_comb begin
    // The sync byte is offered straight from the accept so its start bit follows at once.
    accept     = ~busy_q & sl_valid;
    byte_valid = busy_q ? (idx_q != IdxEnd) : sl_valid;
    byte_data  = busy_q ? pay_q[7:0] : SYNC_BYTE;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
    if (busy_q && idx_q == IdxCsum) byte_data = csum_q;
`endif
    byte_fire  = busy_q & byte_valid & byte_ready;
    frame_done = busy_q & (idx_q == IdxEnd) & byte_ready;
    busy_d = busy_q;
    idx_d  = idx_q;
    pay_d  = pay_q;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (accept) begin
      busy_d = 1'b1;
      idx_d  = IdxW'(1);
      pay_d  = {sl_data, sl_addr};
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
      csum_d = '0;
`endif
    end else if (byte_fire) begin
      idx_d = idx_q + IdxW'(1);
      pay_d = pay_q >> 8;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
      csum_d = csum_q ^ pay_q[7:0];
`endif
    end else if (frame_done) begin
      busy_d = 1'b0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      pay_q  <= '0;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      busy_q <= busy_d;
      idx_q  <= idx_d;
      pay_q  <= pay_d;
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .STOP_BITS   (STOP_BITS)
  ) u_byte_tx (
    .clk       (clk),
    .reset     (reset),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx        (uart_tx)
  );

  assign sl_ready = ~busy_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_scanline_uart_framer.sv
// Bench for scanline_uart_framer: three configurations checked against a frame/waveform model.
module tb_scanline_uart_framer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic [159:0] data_w = '0;
  logic [7:0]   addr_w = '0;
  logic         ready_a, ready_b, ready_c, tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
  logic         tx_m, ready_m, busy_m;
  int           sel = 0;
  int           total = 0;
  int           bad = 0;
  int           acc_cnt = 0;
  logic [7:0]   exp_bytes[$];
  logic         exp_bits[$];

  always #5 clk = ~clk;

  scanline_uart_framer #(.LINE_BITS(16), .ADDR_BYTES(1), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(rst), .sl_valid(valid_a), .sl_data(data_w[15:0]), .sl_addr(addr_w),
    .sl_ready(ready_a), .uart_tx(tx_a), .busy(busy_a));

  scanline_uart_framer #(.LINE_BITS(16), .ADDR_BYTES(1), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(rst), .sl_valid(valid_b), .sl_data(data_w[15:0]), .sl_addr(addr_w),
    .sl_ready(ready_b), .uart_tx(tx_b), .busy(busy_b));

  scanline_uart_framer #(.LINE_BITS(160), .ADDR_BYTES(1), .CLKS_PER_BIT(1), .STOP_BITS(1)) dut_c (
    .clk(clk), .reset(rst), .sl_valid(valid_c), .sl_data(data_w), .sl_addr(addr_w),
    .sl_ready(ready_c), .uart_tx(tx_c), .busy(busy_c));

  assign tx_m    = (sel == 0) ? tx_a : (sel == 1) ? tx_b : tx_c;
  assign ready_m = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;
  assign busy_m  = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;

  always @(posedge clk)
    if ((valid_a && ready_a) || (valid_b && ready_b) || (valid_c && ready_c))
      acc_cnt <= acc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: byte list from the framing rules, then the per-cycle line level.
  task automatic build_exp(input logic [7:0] addr, input logic [159:0] data, input int lbytes,
                           input int cpb, input int stop);
    logic [7:0] b, x;
    exp_bytes = {};
    exp_bits  = {};
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(addr);
    x = addr;
    for (int i = 0; i < lbytes; i++) begin
      b = data[8*i +: 8];
      exp_bytes.push_back(b);
      x = x ^ b;
    end
`ifdef SCANLINE_FRAMER_CHECKSUM_EN
    exp_bytes.push_back(x);
`endif
    foreach (exp_bytes[n]) begin
      b = exp_bytes[n];
      for (int c = 0; c < cpb; c++) exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < cpb; c++) exp_bits.push_back(b[j]);
      for (int c = 0; c < stop * cpb; c++) exp_bits.push_back(1'b1);
    end
  endtask

  // Drives one line; returns #1 after the accept edge.
  task automatic start_line(input int s, input logic [7:0] addr, input logic [159:0] data,
                            input bit keep);
    int a0;
    sel = s;
    @(negedge clk);
    addr_w = addr;
    data_w = data;
    if (s == 0) valid_a = 1'b1; else if (s == 1) valid_b = 1'b1; else valid_c = 1'b1;
    a0 = acc_cnt;
    check($sformatf("ready_before_accept_s%0d", s), 32'(ready_m), 32'd1);
    @(posedge clk);
    #1;
    check($sformatf("accept_pulse_s%0d", s), 32'(acc_cnt - a0), 32'd1);
    if (!keep) begin
      valid_a = 1'b0;
      valid_b = 1'b0;
      valid_c = 1'b0;
      data_w  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      addr_w  = 8'($urandom);
    end
  endtask

  // Called #1 after an accept edge; checks the whole frame and the following idle cycle.
  task automatic check_frame(input string tag, input logic [7:0] addr, input logic [159:0] data,
                             input int lbytes, input int cpb, input int stop);
    int   werr, herr, bt;
    logic samp[$];
    logic [7:0] d;
    build_exp(addr, data, lbytes, cpb, stop);
    werr = 0;
    herr = 0;
    for (int k = 0; k < exp_bits.size(); k++) begin
      @(negedge clk);
      samp.push_back(tx_m);
      if (tx_m !== exp_bits[k]) werr++;
      if (busy_m !== 1'b1 || ready_m !== 1'b0) herr++;
    end
    check({tag, "_wave_errs"}, 32'(werr), 32'd0);
    check({tag, "_busy_ready_errs"}, 32'(herr), 32'd0);
    bt = (9 + stop) * cpb;
    foreach (exp_bytes[b]) begin
      for (int j = 0; j < 8; j++) d[j] = samp[b * bt + (j + 1) * cpb + cpb / 2];
      check($sformatf("%s_byte%0d", tag, b), 32'(d), 32'(exp_bytes[b]));
    end
    @(negedge clk);
    check({tag, "_end_tx"}, 32'(tx_m), 32'd1);
    check({tag, "_end_busy"}, 32'(busy_m), 32'd0);
    check({tag, "_end_ready"}, 32'(ready_m), 32'd1);
  endtask

  initial begin
    logic [7:0]   ra;
    logic [159:0] rd;
    int           ierr, a0;

    // Reset state on every configuration.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("rst_tx_s%0d", s), 32'(tx_m), 32'd1);
      check($sformatf("rst_busy_s%0d", s), 32'(busy_m), 32'd0);
      check($sformatf("rst_ready_s%0d", s), 32'(ready_m), 32'd1);
    end
    @(negedge clk);
    rst = 1'b0;

    // Idle with sl_valid low.
    sel  = 0;
    ierr = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) ierr++;
    end
    check("idle_errs", 32'(ierr), 32'd0);

    // Basic frame, including sync-byte bit timing.
    start_line(0, 8'h03, 160'h1234, 1'b0);
    check_frame("basic", 8'h03, 160'h1234, 2, 4, 1);

    // Randomised lines.
    for (int r = 0; r < 3; r++) begin
      ra = 8'($urandom);
      rd = 160'($urandom);
      start_line(0, ra, rd, 1'b0);
      check_frame($sformatf("rand%0d", r), ra, rd, 2, 4, 1);
    end

    // Two stop bits.
    start_line(1, 8'h03, 160'h1234, 1'b0);
    check_frame("stop2", 8'h03, 160'h1234, 2, 4, 2);
    ra = 8'($urandom);
    rd = 160'($urandom);
    start_line(1, ra, rd, 1'b0);
    check_frame("stop2_rand", ra, rd, 2, 4, 2);

    // Back-to-back with sl_valid held high.
    a0 = acc_cnt;
    start_line(0, 8'h01, 160'hAAAA, 1'b1);
    addr_w = 8'h02;
    data_w = 160'h5555;
    check_frame("b2b_first", 8'h01, 160'hAAAA, 2, 4, 1);
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    check("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    check_frame("b2b_second", 8'h02, 160'h5555, 2, 4, 1);

    // Asynchronous reset during a data byte.
    start_line(0, 8'h77, 160'hBEEF, 1'b0);
    repeat (130) @(negedge clk);
    check("pre_reset_busy", 32'(busy_a), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_a), 32'd1);
    check("async_rst_busy", 32'(busy_a), 32'd0);
    check("async_rst_ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ra = 8'($urandom);
    rd = 160'($urandom);
    start_line(0, ra, rd, 1'b0);
    check_frame("post_reset", ra, rd, 2, 4, 1);

    // One bit per clock, 160-bit line.
    ra = 8'($urandom);
    rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    start_line(2, ra, rd, 1'b0);
    check_frame("wide", ra, rd, 20, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
